// File: rtl/stall_control_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// This package holds the FSM state encoding and the default pipeline-register widths.
package stall_control_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam int unsigned DefaultInstrBits = 16;
    localparam int unsigned DefaultPcBits    = 16;
    localparam int unsigned DefaultCountBits = 16;
    localparam int unsigned DefaultMaxStall  = 4;

endpackage

// File: rtl/stall_control_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module stall_control_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stall_control.sv
// IF/ID pipeline register control: load-use stalls, branch flushes, event counters and
// a sticky watchdog for runaway stalls.
module stall_control
    import stall_control_pkg::*;
#(
    parameter int unsigned InstrBits = DefaultInstrBits,
    parameter int unsigned PCBits    = DefaultPcBits,
    parameter int unsigned CountBits = DefaultCountBits,
    parameter int unsigned MaxStall  = DefaultMaxStall
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Stall,
    input  logic                 Branch_Taken,
    input  logic [InstrBits-1:0] IF_Instr,
    input  logic [PCBits-1:0]    IF_PC_Next,
    output logic                 PC_Write,
    output logic [InstrBits-1:0] IF_ID_Instr,
    output logic [PCBits-1:0]    IF_ID_PC,
    output logic                 IF_ID_Valid,
    output logic                 ID_EX_Bubble,
    output logic [CountBits-1:0] Stall_Count,
    output logic [CountBits-1:0] Flush_Count,
    output logic                 Deadlock
);

    state_e               state_q, state_d;
    logic [InstrBits-1:0] if_id_instr_q;
    logic [PCBits-1:0]    if_id_pc_q;
    logic                 if_id_valid_q;
    logic                 deadlock_q;
    logic                 eff_stall;
    logic [CountBits-1:0] consec_count;

    // A stall only bites when ID holds a live instruction and no branch squashes it.
    assign eff_stall    = Stall && if_id_valid_q && !Branch_Taken;
    assign PC_Write     = !eff_stall;
    assign ID_EX_Bubble = (Stall && if_id_valid_q) || Branch_Taken || !if_id_valid_q;

    always_comb begin
        state_d = StRun;
        unique case (state_q)
            StRun: begin
                if (Branch_Taken)               state_d = StFlush;
                else if (Stall && if_id_valid_q) state_d = StStall;
                else                             state_d = StRun;
            end
            StStall: begin
                if (Branch_Taken) state_d = StFlush;
                else if (Stall)   state_d = StStall;
                else              state_d = StRun;
            end
            StFlush: begin
                if (Branch_Taken) state_d = StFlush;
                else              state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            deadlock_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (Branch_Taken) begin
                if_id_instr_q <= '0;
                if_id_pc_q    <= '0;
                if_id_valid_q <= 1'b0;
            end else if (!eff_stall) begin
                if_id_instr_q <= IF_Instr;
                if_id_pc_q    <= IF_PC_Next;
                if_id_valid_q <= 1'b1;
            end
            // This edge completes the MaxStall-th consecutive stall cycle.
            if (eff_stall && (consec_count >= CountBits'(MaxStall - 1))) begin
                deadlock_q <= 1'b1;
            end
        end
    end

    stall_control_sat_counter #(
        .Width(CountBits)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (eff_stall),
        .clear(1'b0),
        .count(Stall_Count)
    );

    stall_control_sat_counter #(
        .Width(CountBits)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (Branch_Taken),
        .clear(1'b0),
        .count(Flush_Count)
    );

    stall_control_sat_counter #(
        .Width(CountBits)
    ) u_consec_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (eff_stall),
        .clear(!eff_stall),
        .count(consec_count)
    );

    assign IF_ID_Instr = if_id_instr_q;
    assign IF_ID_PC    = if_id_pc_q;
    assign IF_ID_Valid = if_id_valid_q;
    assign Deadlock    = deadlock_q;

endmodule

// File: tb/tb_stall_control.sv
// Directed bench for stall_control: stall, flush, watchdog, saturation and async reset.
module tb_stall_control;
    import stall_control_pkg::*;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        Branch_Taken;
    logic [15:0] IF_Instr;
    logic [15:0] IF_PC_Next;
    logic        PC_Write;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PC;
    logic        IF_ID_Valid;
    logic        ID_EX_Bubble;
    logic [15:0] Stall_Count;
    logic [15:0] Flush_Count;
    logic        Deadlock;

    int total;
    int bad;

    stall_control #(
        .InstrBits(16),
        .PCBits   (16),
        .CountBits(16),
        .MaxStall (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Stall       (Stall),
        .Branch_Taken(Branch_Taken),
        .IF_Instr    (IF_Instr),
        .IF_PC_Next  (IF_PC_Next),
        .PC_Write    (PC_Write),
        .IF_ID_Instr (IF_ID_Instr),
        .IF_ID_PC    (IF_ID_PC),
        .IF_ID_Valid (IF_ID_Valid),
        .ID_EX_Bubble(ID_EX_Bubble),
        .Stall_Count (Stall_Count),
        .Flush_Count (Flush_Count),
        .Deadlock    (Deadlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        Stall        = 1'b0;
        Branch_Taken = 1'b0;
        IF_Instr     = 16'h0000;
        IF_PC_Next   = 16'h0000;
        #12;
        check_eq("rst_pc_write", 32'(PC_Write), 32'd1);
        check_eq("rst_bubble", 32'(ID_EX_Bubble), 32'd1);
        check_eq("rst_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("rst_stall_cnt", 32'(Stall_Count), 32'd0);
        check_eq("rst_flush_cnt", 32'(Flush_Count), 32'd0);
        check_eq("rst_deadlock", 32'(Deadlock), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(StRun));
        rst = 1'b0;

        // Plain load, one clock latency.
        IF_Instr   = 16'h1234;
        IF_PC_Next = 16'h0001;
        tick();
        check_eq("load_instr", 32'(IF_ID_Instr), 32'h1234);
        check_eq("load_pc", 32'(IF_ID_PC), 32'h0001);
        check_eq("load_valid", 32'(IF_ID_Valid), 32'd1);
        check_eq("load_pc_write", 32'(PC_Write), 32'd1);
        check_eq("load_bubble", 32'(ID_EX_Bubble), 32'd0);

        // Single stall cycle.
        Stall      = 1'b1;
        IF_Instr   = 16'h5678;
        IF_PC_Next = 16'h0002;
        #1;
        check_eq("stall_pc_write", 32'(PC_Write), 32'd0);
        check_eq("stall_bubble", 32'(ID_EX_Bubble), 32'd1);
        tick();
        check_eq("stall_hold_instr", 32'(IF_ID_Instr), 32'h1234);
        check_eq("stall_hold_pc", 32'(IF_ID_PC), 32'h0001);
        check_eq("stall_count_1", 32'(Stall_Count), 32'd1);
        check_eq("stall_state", 32'(dut.state_q), 32'(StStall));
        Stall = 1'b0;
        tick();
        check_eq("unstall_instr", 32'(IF_ID_Instr), 32'h5678);
        check_eq("unstall_pc", 32'(IF_ID_PC), 32'h0002);
        check_eq("unstall_state", 32'(dut.state_q), 32'(StRun));

        // Branch overrides stall in the same cycle.
        Stall        = 1'b1;
        Branch_Taken = 1'b1;
        IF_Instr     = 16'h9abc;
        IF_PC_Next   = 16'h0003;
        #1;
        check_eq("br_pc_write", 32'(PC_Write), 32'd1);
        check_eq("br_bubble", 32'(ID_EX_Bubble), 32'd1);
        tick();
        check_eq("br_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("br_instr_clr", 32'(IF_ID_Instr), 32'd0);
        check_eq("br_flush_cnt", 32'(Flush_Count), 32'd1);
        check_eq("br_stall_cnt", 32'(Stall_Count), 32'd1);
        check_eq("br_state_flush", 32'(dut.state_q), 32'(StFlush));
        Stall        = 1'b0;
        Branch_Taken = 1'b0;
        tick();
        check_eq("br_state_run", 32'(dut.state_q), 32'(StRun));
        check_eq("br_reload", 32'(IF_ID_Instr), 32'h9abc);

        // Stall against a bubble in ID is ignored.
        Branch_Taken = 1'b1;
        tick();
        Branch_Taken = 1'b0;
        Stall        = 1'b1;
        IF_Instr     = 16'h4444;
        #1;
        check_eq("bub_pc_write", 32'(PC_Write), 32'd1);
        tick();
        check_eq("bub_load", 32'(IF_ID_Instr), 32'h4444);
        check_eq("bub_valid", 32'(IF_ID_Valid), 32'd1);
        check_eq("bub_stall_cnt", 32'(Stall_Count), 32'd1);
        check_eq("bub_flush_cnt", 32'(Flush_Count), 32'd2);
        check_eq("bub_state", 32'(dut.state_q), 32'(StRun));

        // Watchdog: four consecutive stalls.
        for (int i = 0; i < 3; i++) tick();
        check_eq("wd_not_yet", 32'(Deadlock), 32'd0);
        tick();
        check_eq("wd_set", 32'(Deadlock), 32'd1);
        check_eq("wd_stall_cnt", 32'(Stall_Count), 32'd5);
        Stall    = 1'b0;
        IF_Instr = 16'h5555;
        tick();
        check_eq("wd_sticky", 32'(Deadlock), 32'd1);
        check_eq("wd_still_runs", 32'(IF_ID_Instr), 32'h5555);

        // Saturation of the stall counter.
        Stall = 1'b1;
        for (int i = 0; i < 16'hfffe - 5; i++) tick();
        check_eq("sat_fffe", 32'(Stall_Count), 32'hfffe);
        for (int i = 0; i < 3; i++) tick();
        check_eq("sat_ffff", 32'(Stall_Count), 32'hffff);
        check_eq("sat_state", 32'(dut.state_q), 32'(StStall));

        // Short async reset mid-stall with no clock edge.
        rst = 1'b1;
        #3;
        check_eq("arst_instr", 32'(IF_ID_Instr), 32'd0);
        check_eq("arst_pc", 32'(IF_ID_PC), 32'd0);
        check_eq("arst_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("arst_stall_cnt", 32'(Stall_Count), 32'd0);
        check_eq("arst_flush_cnt", 32'(Flush_Count), 32'd0);
        check_eq("arst_deadlock", 32'(Deadlock), 32'd0);
        check_eq("arst_state", 32'(dut.state_q), 32'(StRun));
        check_eq("arst_pc_write", 32'(PC_Write), 32'd1);
        check_eq("arst_bubble", 32'(ID_EX_Bubble), 32'd1);
        rst        = 1'b0;
        Stall      = 1'b0;
        IF_Instr   = 16'hbeef;
        IF_PC_Next = 16'h0007;
        tick();
        check_eq("post_rst_instr", 32'(IF_ID_Instr), 32'hbeef);
        check_eq("post_rst_pc", 32'(IF_ID_PC), 32'h0007);
        check_eq("post_rst_valid", 32'(IF_ID_Valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
